// File: rtl/div_32.sv
// Sequential signed 32-bit divider: one quotient bit per clock, fixed 35-edge start-to-ready latency.
// Define DIV_REMAINDER_EN to add the data_remainder output port and its output register.
//
// state | meaning
// IDLE  | waiting for ctrl_DIV
// BUSY  | 32 restoring iterations on operand magnitudes
// FIX   | apply signs, publish quotient/remainder/exception
// DONE  | raise the one-cycle data_resultRDY pulse
module div_32 (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_DIV,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
`ifdef DIV_REMAINDER_EN
   ,
   output logic [31:0] data_remainder
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

   state_t      state;
   logic [4:0]  count;
   logic [31:0] quo_reg;
   logic [31:0] rem_reg;
   logic [31:0] div_mag;
   logic        sign_a;
   logic        sign_b;
   logic        div_zero;

   logic [32:0] shifted;
   logic [32:0] diff;
   logic        fits;
   logic [31:0] mag_a;
   logic [31:0] mag_b;

   // The partial remainder always stays below the divisor, so a non-negative difference never sets bit 32.
   always_comb begin
      shifted = {rem_reg, quo_reg[31]};
      diff    = shifted - {1'b0, div_mag};
      fits    = ~diff[32];
      mag_a   = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
      mag_b   = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         count          <= 5'd0;
         quo_reg        <= 32'd0;
         rem_reg        <= 32'd0;
         div_mag        <= 32'd0;
         sign_a         <= 1'b0;
         sign_b         <= 1'b0;
         div_zero       <= 1'b0;
         data_result    <= 32'd0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
         data_remainder <= 32'd0;
`endif
      end else begin
         data_resultRDY <= 1'b0;
         if (ctrl_DIV) begin
            // A completed operation still reports even if a new one starts on its DONE edge.
            if (state == DONE)
               data_resultRDY <= 1'b1;
            state    <= BUSY;
            count    <= 5'd0;
            quo_reg  <= mag_a;
            rem_reg  <= 32'd0;
            div_mag  <= mag_b;
            sign_a   <= data_operandA[31];
            sign_b   <= data_operandB[31];
            div_zero <= (data_operandB == 32'd0);
         end else begin
            case (state)
               BUSY: begin
                  rem_reg <= fits ? diff[31:0] : shifted[31:0];
                  quo_reg <= {quo_reg[30:0], fits};
                  count   <= count + 5'd1;
                  if (count == 5'd31)
                     state <= FIX;
               end
               FIX: begin
                  if (div_zero)
                     data_result <= 32'd0;
                  else if (sign_a ^ sign_b)
                     data_result <= ~quo_reg + 32'd1;
                  else
                     data_result <= quo_reg;
                  data_exception <= div_zero;
`ifdef DIV_REMAINDER_EN
                  // With a zero divisor rem_reg ends as |dividend|, so this also returns the dividend.
                  data_remainder <= sign_a ? (~rem_reg + 32'd1) : rem_reg;
`endif
                  state <= DONE;
               end
               DONE: begin
                  data_resultRDY <= 1'b1;
                  state          <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_div_32.sv
// Directed self-checking bench for div_32; remainder checks are active when DIV_REMAINDER_EN is defined.
module tb_div_32;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
`ifdef DIV_REMAINDER_EN
   logic [31:0] data_remainder;
`endif

   int checks   = 0;
   int failures = 0;

   div_32 dut (
      .clock         (clock),
      .reset         (reset),
      .ctrl_DIV      (ctrl_DIV),
      .data_operandA (data_operandA),
      .data_operandB (data_operandB),
      .data_result   (data_result),
      .data_exception(data_exception),
      .data_resultRDY(data_resultRDY)
`ifdef DIV_REMAINDER_EN
      ,
      .data_remainder(data_remainder)
`endif
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue a start at the next rising edge (E0), then scramble operands to show they are not resampled.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      ctrl_DIV      = 1'b1;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic wait_done(input string tag, input logic [31:0] exp_q,
                            input logic [31:0] exp_r, input logic exp_e);
      logic early;
      early = 1'b0;
      repeat (33) begin
         @(posedge clock);
         #1;
         if (data_resultRDY !== 1'b0) early = 1'b1;
      end
      chk({tag, "_no_early_rdy"}, {31'd0, early}, 32'd0);
      @(posedge clock);
      #1;
      chk({tag, "_rdy_e34"}, {31'd0, data_resultRDY}, 32'd1);
      chk({tag, "_quot"}, data_result, exp_q);
      chk({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_e});
`ifdef DIV_REMAINDER_EN
      chk({tag, "_rem"}, data_remainder, exp_r);
`else
      if (exp_r === 32'hxxxxxxxx) chk({tag, "_rem_unused"}, 32'd1, 32'd0);
`endif
      @(posedge clock);
      #1;
      chk({tag, "_rdy_single"}, {31'd0, data_resultRDY}, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic [31:0] exp_r, input logic exp_e);
      start_op(a, b);
      wait_done(tag, exp_q, exp_r, exp_e);
   endtask

   task automatic expect_quiet(input string tag, input int n);
      logic seen;
      seen = 1'b0;
      repeat (n) begin
         @(posedge clock);
         #1;
         if (data_resultRDY !== 1'b0) seen = 1'b1;
      end
      chk(tag, {31'd0, seen}, 32'd0);
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_quot0"}, data_result, 32'd0);
      chk({tag, "_exc0"}, {31'd0, data_exception}, 32'd0);
      chk({tag, "_rdy0"}, {31'd0, data_resultRDY}, 32'd0);
`ifdef DIV_REMAINDER_EN
      chk({tag, "_rem0"}, data_remainder, 32'd0);
`endif
   endtask

   initial begin
      reset         = 1'b1;
      ctrl_DIV      = 1'b0;
      data_operandA = 32'd0;
      data_operandB = 32'd0;
      repeat (2) @(posedge clock);
      #1;
      chk_cleared("reset");
      reset = 1'b0;

      run_op("p100_d7",   32'd100,         32'd7,          32'd14,         32'd2,          1'b0);
      run_op("m100_d7",   32'hFFFFFF9C,    32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0);
      run_op("p100_dm7",  32'd100,         32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0);
      run_op("m100_dm7",  32'hFFFFFF9C,    32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0);
      run_op("p5_d0",     32'd5,           32'd0,          32'd0,          32'd5,          1'b1);
      run_op("m7_d0",     32'hFFFFFFF9,    32'd0,          32'd0,          32'hFFFFFFF9,   1'b1);
      run_op("min_dm1",   32'h80000000,    32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0);
      run_op("big_div",   32'hFFFFFFFF,    32'h7FFFFFFF,   32'd0,          32'hFFFFFFFF,   1'b0);
      run_op("max_d1",    32'h7FFFFFFF,    32'd1,          32'h7FFFFFFF,   32'd0,          1'b0);

      // Restart at E10: only the second operation reports, earlier results hold meanwhile.
      start_op(32'd100, 32'd7);
      expect_quiet("abort_quiet", 9);
      chk("abort_hold_quot", data_result, 32'h7FFFFFFF);
      run_op("restart_9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

      // Reset at E20 aborts silently and clears outputs.
      start_op(32'd100, 32'd7);
      repeat (19) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      chk_cleared("midreset");
      expect_quiet("midreset_quiet", 40);
      run_op("after_reset_8_2", 32'd8, 32'd2, 32'd4, 32'd0, 1'b0);

      // Reset wins over a simultaneous start.
      @(negedge clock);
      reset         = 1'b1;
      ctrl_DIV      = 1'b1;
      data_operandA = 32'd8;
      data_operandB = 32'd2;
      @(posedge clock);
      #1;
      reset    = 1'b0;
      ctrl_DIV = 1'b0;
      expect_quiet("rst_vs_start_quiet", 40);
      chk("rst_vs_start_quot", data_result, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/div_32.md
DIV_32 -- requirements
Module: div_32

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port ctrl_DIV, input, 1, start pulse; sampled on the rising edge of clock.
REQ-004 SHALL have port data_operandA, input, 32, signed two's-complement dividend; sampled only on the edge where ctrl_DIV=1.
REQ-005 SHALL have port data_operandB, input, 32, signed two's-complement divisor; sampled only on the edge where ctrl_DIV=1.
REQ-006 SHALL have port data_result, output, 32, signed quotient truncated toward zero.
REQ-007 SHALL have port data_exception, output, 1, high when the completed operation was divide-by-zero.
REQ-008 SHALL have port data_resultRDY, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port data_remainder, output, 32, signed remainder; present only when DIV_REMAINDER_EN is defined.

Function
REQ-010 SHALL use states IDLE, BUSY, FIX, DONE.
REQ-011 SHALL, on any edge with ctrl_DIV=1 and reset=0, latch operand magnitudes and both signs, clear a 5-bit iteration counter and enter BUSY from any state.
REQ-012 SHALL, in BUSY, retire exactly one quotient bit per edge using a 32-bit subtract of the divisor magnitude from the shifted partial remainder (non-restoring or restoring, same results).
REQ-013 SHALL, in BUSY, leave for FIX on the edge where the counter wraps 31->0, after 32 iterations.
REQ-014 SHALL, in FIX, negate the quotient when the operand signs differ and give the remainder the sign of the dividend, then enter DONE.
REQ-015 SHALL, in DONE, assert data_resultRDY for exactly one cycle and return to IDLE on the next edge unless ctrl_DIV=1.
REQ-016 SHALL have fixed latency: with ctrl_DIV sampled at edge E0, data_resultRDY is high in the cycle following edge E34.
REQ-017 SHALL, on divisor 0, run the same latency and deliver data_result=0, data_exception=1 and data_remainder=dividend.
REQ-018 SHALL, for 0x80000000 / 0xFFFFFFFF, deliver data_result=0x80000000, data_remainder=0 and data_exception=0, with no trap.
REQ-019 SHALL, on ctrl_DIV=1 while BUSY or FIX, abort the current operation with no data_resultRDY pulse for it and restart per REQ-011.
REQ-020 SHALL hold data_result, data_remainder and data_exception stable from DONE until the FIX state of the next completed operation.
REQ-021 SHALL ignore operand input changes outside the sampling edge.

Reset
REQ-022 SHALL, on an edge with reset=1, enter IDLE and clear data_result, data_remainder, data_exception, data_resultRDY and the counter to 0.
REQ-023 SHALL give reset priority over a simultaneous ctrl_DIV=1, which is discarded.
REQ-024 SHALL, on reset mid-operation, abort with no data_resultRDY pulse.

Configuration
REQ-025 SHALL, with DIV_REMAINDER_EN defined, expose data_remainder with the behaviour of REQ-014, REQ-017, REQ-018 and REQ-020.
REQ-026 SHALL, without DIV_REMAINDER_EN, omit the data_remainder port and its output register while leaving quotient, exception and timing unchanged.

Verification
REQ-027 SHALL cover: 100 / 7 -> data_result=14, remainder=2, exception=0, ready pulse after edge E34 only.
REQ-028 SHALL cover: -100 / 7 -> data_result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); and 100 / -7 -> -14, remainder 2.
REQ-029 SHALL cover: 5 / 0 -> data_result=0, exception=1, remainder=5, ready after E34.
REQ-030 SHALL cover: 0x80000000 / 0xFFFFFFFF -> data_result=0x80000000, exception=0, remainder=0.
REQ-031 SHALL cover: start 100/7, ctrl_DIV again at E10 with 9/3 -> single ready pulse 34 edges after E10, data_result=3.
REQ-032 SHALL cover: reset at E20 of an operation -> no ready pulse, all outputs 0, and a following 8/2 returns 4.
